// File: rtl/matrix_pkg.sv
// Shared face-matrix definitions: face identifiers, the four 8x8 bitmaps and
// the exact-match classifier used by both the face driver and the receiver.
package matrix_pkg;

    typedef enum logic [1:0] {
        FACE_HAPPY = 2'd0,
        FACE_SAD   = 2'd1,
        FACE_ANGRY = 2'd2,
        FACE_SLEEP = 2'd3
    } face_e;

    // Row 0 sits in bits [63:56], row 7 in bits [7:0].
    localparam logic [63:0] PAT_HAPPY = 64'hFF81_A581_A599_81FF;
    localparam logic [63:0] PAT_SAD   = 64'hFF81_A581_99A5_81FF;
    localparam logic [63:0] PAT_ANGRY = 64'hFFC3_A5A5_8199_A5FF;
    localparam logic [63:0] PAT_SLEEP = 64'hFF81_81E7_8199_99FF;

    typedef struct packed {
        logic  match;
        face_e id;
    } face_class_t;

    function automatic face_class_t classify_face(input logic [63:0] f);
        face_class_t r;
        r.match = 1'b1;
        r.id    = FACE_HAPPY;
        if (f == PAT_HAPPY)      r.id = FACE_HAPPY;
        else if (f == PAT_SAD)   r.id = FACE_SAD;
        else if (f == PAT_ANGRY) r.id = FACE_ANGRY;
        else if (f == PAT_SLEEP) r.id = FACE_SLEEP;
        else                     r.match = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/spi_slave_shift.sv
// SPI mode-0 slave front end: synchronises sclk/mosi/cs into clk, detects
// edges and assembles MSB-first bytes, flagging bytes cut short by cs.
module spi_slave_shift (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk_i,
    input  logic       mosi_i,
    input  logic       cs_i,
    input  logic       clr_i,
    output logic       byte_strobe_o,
    output logic [7:0] byte_o,
    output logic       cs_abort_o
);

    logic [2:0] sclk_sync_q;
    logic [2:0] cs_sync_q;
    logic [1:0] mosi_sync_q;
    logic [6:0] shreg_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] byte_q;
    logic       byte_strobe_q;
    logic       cs_abort_q;

    logic sclk_rise, cs_fall, cs_rise, shift_en, last_bit;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1] &  cs_sync_q[2];
    assign cs_rise   =  cs_sync_q[1] & ~cs_sync_q[2];
    // Gating on the older cs sample lets an sclk edge coincident with the cs
    // rise still complete its byte, while the cs-fall cycle shifts nothing.
    assign shift_en  = sclk_rise & ~cs_sync_q[2];
    assign last_bit  = shift_en && (bit_cnt_q == 3'd7);

    // NOTE: every sequential update uses <= so all flops sample the
    // pre-edge values, exactly like the hardware they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q   <= 3'b000;
            cs_sync_q     <= 3'b111;
            mosi_sync_q   <= 2'b00;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            byte_q        <= '0;
            byte_strobe_q <= 1'b0;
            cs_abort_q    <= 1'b0;
        end else begin
            sclk_sync_q   <= {sclk_sync_q[1:0], sclk_i};
            cs_sync_q     <= {cs_sync_q[1:0], cs_i};
            mosi_sync_q   <= {mosi_sync_q[0], mosi_i};
            byte_strobe_q <= 1'b0;
            cs_abort_q    <= 1'b0;
            if (clr_i || cs_fall) begin
                bit_cnt_q <= '0;
            end else if (cs_rise && !last_bit && (bit_cnt_q != 3'd0 || shift_en)) begin
                bit_cnt_q  <= '0;
                cs_abort_q <= 1'b1;
            end else if (shift_en) begin
                shreg_q   <= {shreg_q[5:0], mosi_sync_q[1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (last_bit) begin
                    byte_q        <= {shreg_q, mosi_sync_q[1]};
                    byte_strobe_q <= 1'b1;
                end
            end
        end
    end

    assign byte_strobe_o = byte_strobe_q;
    assign byte_o        = byte_q;
    assign cs_abort_o    = cs_abort_q;

endmodule

// File: rtl/spi_frame_receiver.sv
// Face-matrix SPI receiver: collects eight bytes into a frame, publishes it
// atomically with its face classification and discards broken frames.
module spi_frame_receiver
    import matrix_pkg::*;
#(
    parameter int unsigned IDLE_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        frame_valid,
    output logic [63:0] frame,
    output logic [1:0]  face_id,
    output logic        face_match,
    output logic        frame_err
);

    localparam logic [31:0] TMO = 32'(IDLE_TIMEOUT);

    logic        byte_strobe;
    logic [7:0]  byte_w;
    logic        cs_abort;
    logic        tmo_hit;

    logic [55:0] rows_q;
    logic [2:0]  row_idx_q;
    logic [31:0] idle_cnt_q;
    logic [63:0] frame_q;
    face_class_t face_q;
    logic        frame_valid_q;
    logic        tmo_err_q;
    logic [63:0] frame_full;

    spi_slave_shift u_shift (
        .clk           (clk),
        .reset         (reset),
        .sclk_i        (sclk),
        .mosi_i        (mosi),
        .cs_i          (cs),
        .clr_i         (tmo_hit),
        .byte_strobe_o (byte_strobe),
        .byte_o        (byte_w),
        .cs_abort_o    (cs_abort)
    );

    // Earlier rows shift toward the MSBs, so row 0 lands in [63:56].
    assign frame_full = {rows_q, byte_w};

    assign tmo_hit = (TMO != 32'd0) && (idle_cnt_q == TMO - 32'd1)
                     && (row_idx_q != 3'd0) && !byte_strobe;

    // NOTE: the row store is plain data qualified by row_idx_q, so it carries
    // no reset; only control state and outputs are reset.
    always_ff @(posedge clk) begin
        if (byte_strobe) rows_q <= {rows_q[47:0], byte_w};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_idx_q     <= '0;
            idle_cnt_q    <= '0;
            frame_q       <= '0;
            face_q        <= '0;
            frame_valid_q <= 1'b0;
            tmo_err_q     <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            tmo_err_q     <= tmo_hit;
            if (byte_strobe)             idle_cnt_q <= '0;
            else if (idle_cnt_q != TMO)  idle_cnt_q <= idle_cnt_q + 32'd1;

            if (cs_abort || tmo_hit) begin
                row_idx_q <= '0;
            end else if (byte_strobe) begin
                row_idx_q <= row_idx_q + 3'd1;
                if (row_idx_q == 3'd7) begin
                    frame_q       <= frame_full;
                    face_q        <= classify_face(frame_full);
                    frame_valid_q <= 1'b1;
                end
            end
        end
    end

    assign byte_valid  = byte_strobe;
    assign byte_data   = byte_w;
    assign frame_valid = frame_valid_q;
    assign frame       = frame_q;
    assign face_id     = face_q.id;
    assign face_match  = face_q.match;
    assign frame_err   = cs_abort | tmo_err_q;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Self-checking bench: directed SPI byte streams against a transaction-level
// frame model, with literal expectations pinning the model at checkpoints.
module tb_spi_frame_receiver;

    logic        clk = 1'b0;
    logic        reset, sclk, mosi, cs;
    logic        byte_valid, frame_valid, face_match, frame_err;
    logic [7:0]  byte_data;
    logic [63:0] frame;
    logic [1:0]  face_id;

    spi_frame_receiver #(.IDLE_TIMEOUT(100)) dut (
        .clk         (clk),
        .reset       (reset),
        .sclk        (sclk),
        .mosi        (mosi),
        .cs          (cs),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .frame_valid (frame_valid),
        .frame       (frame),
        .face_id     (face_id),
        .face_match  (face_match),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] F_HAPPY = 64'hFF81A581A59981FF;
    localparam logic [63:0] F_SAD   = 64'hFF81A58199A581FF;
    localparam logic [63:0] F_ANGRY = 64'hFFC3A5A58199A5FF;
    localparam logic [63:0] F_SLEEP = 64'hFF8181E7819999FF;
    localparam logic [63:0] F_55    = 64'h5555555555555555;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model state.
    logic [7:0]  exp_q[$];
    logic [7:0]  rows_m[$];
    logic [7:0]  log_q[$];
    logic [7:0]  exp_byte;
    logic [63:0] exp_frame, pend;
    logic [1:0]  exp_id;
    logic        exp_match;
    bit          due;
    int          err_budget = 0;
    int          n_frames = 0, n_errs = 0, n_bytes = 0;

    function automatic void classify(input logic [63:0] f, output logic [1:0] id, output logic m);
        logic [63:0] pats [4];
        pats[0] = F_HAPPY; pats[1] = F_SAD; pats[2] = F_ANGRY; pats[3] = F_SLEEP;
        m  = 1'b0;
        id = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!m && f == pats[i]) begin
                m  = 1'b1;
                id = 2'(i);
            end
        end
    endfunction

    task automatic model_reset();
        exp_q.delete();
        rows_m.delete();
        exp_byte  = 8'h00;
        exp_frame = 64'h0;
        exp_id    = 2'd0;
        exp_match = 1'b0;
        due       = 1'b0;
    endtask

    initial model_reset();

    // Single compare process, sampling 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                model_reset();
            end else begin
                check("frame_valid timing", frame_valid, due);
                if (frame_valid) n_frames++;
                if (due) begin
                    exp_frame = pend;
                    classify(pend, exp_id, exp_match);
                    due = 1'b0;
                end
                if (frame_err) begin
                    n_errs++;
                    check("frame_err expected", err_budget > 0, 1);
                    if (err_budget > 0) err_budget--;
                    rows_m.delete();
                end
                if (byte_valid) begin
                    n_bytes++;
                    log_q.push_back(byte_data);
                    check("byte_valid with pending byte", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) exp_byte = exp_q.pop_front();
                    rows_m.push_back(exp_byte);
                    if (rows_m.size() == 8) begin
                        pend = '0;
                        for (int i = 0; i < 8; i++) pend = {pend[55:0], rows_m[i]};
                        rows_m.delete();
                        due = 1'b1;
                    end
                end
            end
            check("byte_data", byte_data, exp_byte);
            check("frame", frame, exp_frame);
            check("face_id", face_id, exp_id);
            check("face_match", face_match, exp_match);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] b, input int nbits);
        if (nbits == 8) exp_q.push_back(b);
        cs = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            tick(3);
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
            tick(1);
        end
        tick(2);
        cs   = 1'b1;
        mosi = 1'b0;
        tick(5);
    endtask

    task automatic send_frame(input logic [63:0] f);
        for (int i = 0; i < 8; i++) spi_byte(f[63-8*i -: 8], 8);
    endtask

    task automatic settle();
        tick(10);
        check("all bytes delivered", exp_q.size(), 0);
        check("no frame outstanding", due, 0);
        check("frame_err count", err_budget, 0);
    endtask

    logic [7:0] happy_bytes [8];

    initial begin
        happy_bytes = '{8'hFF, 8'h81, 8'hA5, 8'h81, 8'hA5, 8'h99, 8'h81, 8'hFF};
        reset = 1'b1; sclk = 1'b0; mosi = 1'b0; cs = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(3);
        check("reset byte_valid", byte_valid, 0);
        check("reset byte_data", byte_data, 8'h00);
        check("reset frame", frame, 64'h0);
        check("reset face", {face_match, face_id}, 3'b000);

        // Happy frame, cs toggled per byte.
        send_frame(F_HAPPY);
        settle();
        check("happy frame literal", frame, 64'hFF81A581A59981FF);
        check("happy match/id", {face_match, face_id}, 3'b100);
        check("happy byte count", log_q.size(), 8);
        for (int i = 0; i < 8; i++) check("happy byte literal", log_q[i], happy_bytes[i]);

        // Sleep then angry back to back.
        send_frame(F_SLEEP);
        tick(3);
        check("sleep id literal", {face_match, face_id}, 3'b111);
        send_frame(F_ANGRY);
        settle();
        check("angry id literal", {face_match, face_id}, 3'b110);

        // Non-matching frame.
        send_frame(F_55);
        settle();
        check("0x55 frame literal", frame, 64'h5555555555555555);
        check("0x55 no match", {face_match, face_id}, 3'b000);

        // Partial byte aborted by cs rise, then a clean frame.
        spi_byte(8'h12, 8);
        spi_byte(8'h34, 8);
        err_budget = 1;
        spi_byte(8'hB0, 5);
        settle();
        send_frame(F_HAPPY);
        settle();
        check("post-abort frame literal", frame, 64'hFF81A581A59981FF);
        check("post-abort match", face_match, 1);

        // Idle timeout with a partial frame.
        spi_byte(8'hFF, 8);
        spi_byte(8'h81, 8);
        spi_byte(8'hA5, 8);
        err_budget = 1;
        tick(150);
        settle();
        send_frame(F_SAD);
        settle();
        check("post-timeout sad id", {face_match, face_id}, 3'b101);

        // Reset mid-frame.
        spi_byte(8'hFF, 8);
        spi_byte(8'hC3, 8);
        spi_byte(8'hA5, 8);
        spi_byte(8'hA5, 8);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        check("mid reset frame", frame, 64'h0);
        check("mid reset byte_data", byte_data, 8'h00);
        check("mid reset face", {face_match, face_id}, 3'b000);
        send_frame(F_ANGRY);
        settle();
        check("post-reset angry id", {face_match, face_id}, 3'b110);

        check("total frames", n_frames, 7);
        check("total frame_err", n_errs, 2);
        check("total bytes", n_bytes, 65);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
